// File: rtl/banked_neuron_ram.sv
// banked_neuron_ram: address-interleaved neuron state RAM with a row-sweep clear
// and write-priority arbitration between one write and one read per cycle.
module banked_neuron_ram #(
    parameter int WORD_WIDTH = 309,
    parameter int ADDR_WIDTH = 9,
    parameter int BANK_BITS  = 2
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  ChipEnable,
    input  logic                  Clear,
    output logic                  Busy,
    input  logic                  WrEnable,
    input  logic [ADDR_WIDTH-1:0] WrAddress,
    input  logic [WORD_WIDTH-1:0] WrData,
    output logic                  WrReady,
    input  logic                  RdEnable,
    input  logic [ADDR_WIDTH-1:0] RdAddress,
    output logic                  RdReady,
    output logic [WORD_WIDTH-1:0] RdData,
    output logic                  RdValid
);
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
    localparam logic [ADDR_WIDTH-1:0] BANK_MASK = ADDR_WIDTH'(NUM_BANKS - 1);
    localparam logic [ROW_BITS-1:0]   LAST_ROW  = '1;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                state_q, state_d;
    logic [ROW_BITS-1:0]   clear_row_q, clear_row_d;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_accept, rd_accept, bank_conflict;
    logic [ADDR_WIDTH-1:0] clear_base;
    // Bank b, row r lives at address {r, b}; a sweep row touches one word in every bank.
    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_comb begin
        bank_conflict = ChipEnable && WrEnable && ((WrAddress ^ RdAddress) & BANK_MASK) == '0;
        Busy          = state_q == CLEAR;
        WrReady       = state_q == IDLE;
        RdReady       = state_q == IDLE && !bank_conflict;
        wr_accept     = ChipEnable && WrEnable && WrReady;
        rd_accept     = ChipEnable && RdEnable && RdReady;
        clear_base    = ADDR_WIDTH'(clear_row_q) << BANK_BITS;
        rd_data_d     = rd_accept ? mem[RdAddress] : rd_data_q;
        rd_valid_d    = rd_accept;
        state_d       = Clear ? CLEAR : (state_q == CLEAR && clear_row_q == LAST_ROW) ? IDLE : state_q;
        clear_row_d   = Clear ? '0 : state_q == CLEAR ? clear_row_q + 1'b1 : clear_row_q;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= CLEAR;
            clear_row_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_row_q <= clear_row_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (state_q == CLEAR) begin
            for (int b = 0; b < NUM_BANKS; b++) mem[clear_base | ADDR_WIDTH'(b)] <= '0;
        end else if (wr_accept) begin
            mem[WrAddress] <= WrData;
        end
    end

    assign RdData  = rd_data_q;
    assign RdValid = rd_valid_q;
endmodule

// File: tb/tb_banked_neuron_ram.sv
// tb_banked_neuron_ram: directed tables, hand sequences and random traffic against
// an array-level reference model of the banked neuron RAM.
module tb_banked_neuron_ram;
    localparam int W = 309;
    localparam int A = 9;
    localparam int ROWS = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ce, clr, we, re;
    logic [A-1:0] wa, ra;
    logic [W-1:0] wd, rd_data;
    logic busy, wr_rdy, rd_rdy, rd_val;

    logic s_ce, s_clr, s_we, s_re;
    logic [3:0] s_wa, s_ra;
    logic [7:0] s_wd, s_rd_data;
    logic s_busy, s_wr_rdy, s_rd_rdy, s_rd_val;

    int errors = 0;
    int checks = 0;
    logic last_busy;

    banked_neuron_ram dut (
        .Clock(clk), .ResetN(rst_n), .ChipEnable(ce), .Clear(clr), .Busy(busy),
        .WrEnable(we), .WrAddress(wa), .WrData(wd), .WrReady(wr_rdy),
        .RdEnable(re), .RdAddress(ra), .RdReady(rd_rdy), .RdData(rd_data), .RdValid(rd_val)
    );

    banked_neuron_ram #(.WORD_WIDTH(8), .ADDR_WIDTH(4), .BANK_BITS(0)) sdut (
        .Clock(clk), .ResetN(rst_n), .ChipEnable(s_ce), .Clear(s_clr), .Busy(s_busy),
        .WrEnable(s_we), .WrAddress(s_wa), .WrData(s_wd), .WrReady(s_wr_rdy),
        .RdEnable(s_re), .RdAddress(s_ra), .RdReady(s_rd_rdy), .RdData(s_rd_data), .RdValid(s_rd_val)
    );

    // Reference model: a flat word array, a count of sweep cycles left, and the read pipeline.
    logic [W-1:0] m_mem [2**A];
    int           m_left = ROWS;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_rdy;
    assign m_rdy = (m_left == 0) && !(ce && we && (wa % 4) == (ra % 4));

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left  <= ROWS;
            m_valid <= 1'b0;
            m_data  <= '0;
            for (int i = 0; i < 2**A; i++) m_mem[i] <= '0;
        end else begin
            m_valid <= ce && re && m_rdy;
            if (ce && re && m_rdy) m_data <= m_mem[ra];
            if (m_left == 0 && ce && we) m_mem[wa] <= wd;
            if (clr) begin
                m_left <= ROWS;
                for (int i = 0; i < 2**A; i++) m_mem[i] <= '0;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
            end
        end
    end

    typedef struct {
        logic ce, we, re;
        logic [A-1:0] wa, ra;
        logic [W-1:0] wd;
        logic rdy, val;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic c, input logic w, input logic [A-1:0] wad, input logic [W-1:0] wdat,
                                input logic r, input logic [A-1:0] rad, input logic rdy, input logic val,
                                input logic [W-1:0] data);
        vec_t v;
        v.ce = c; v.we = w; v.wa = wad; v.wd = wdat; v.re = r; v.ra = rad;
        v.rdy = rdy; v.val = val; v.data = data;
        return v;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [319:0] t = '0;
        for (int i = 0; i < 10; i++) t = {t[287:0], 32'($urandom())};
        return t[W-1:0];
    endfunction

    task automatic chkw(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic idle();
        ce = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        last_busy = busy;
        chkb("busy", busy, m_left != 0);
        chkb("wr_ready", wr_rdy, m_left == 0);
        chkb("rd_ready", rd_rdy, m_rdy);
        chkb("rd_valid", rd_val, m_valid);
        chkw("rd_data", rd_data, m_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, sn, cnt, nz;
        rst_n = 1'b0;
        idle();
        wa = '0; ra = '0; wd = '0;
        s_ce = 1'b0; s_clr = 1'b0; s_we = 1'b0; s_re = 1'b0; s_wa = '0; s_ra = '0; s_wd = '0;
        #2;
        chkb("rst_busy", busy, 1'b1);
        chkb("rst_wr_ready", wr_rdy, 1'b0);
        chkb("rst_rd_ready", rd_rdy, 1'b0);
        chkb("rst_rd_valid", rd_val, 1'b0);
        chkw("rst_rd_data", rd_data, '0);
        chkb("rst_small_busy", s_busy, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        n = 0; sn = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (busy) n++;
            if (s_busy) sn++;
            @(posedge clk);
            #1;
        end
        chki("sweep_cycles", n, 128);
        chki("small_sweep_cycles", sn, 16);

        ce = 1'b1; re = 1'b1; ra = 9'h1FF;
        #1 chkb("top_rd_ready", rd_rdy, 1'b1);
        cyc();
        idle();
        chkb("top_rd_valid", rd_val, 1'b1);
        chkw("top_rd_data", rd_data, '0);
        cyc();
        chkb("top_rd_valid_pulse", rd_val, 1'b0);

        tbl[0]  = mk(1, 1, 9'h012, 'hA5, 0, 9'h000, 1, 0, 'h0);
        tbl[1]  = mk(1, 0, 9'h000, 'h0,  1, 9'h012, 1, 1, 'hA5);
        tbl[2]  = mk(1, 0, 9'h000, 'h0,  0, 9'h000, 1, 0, 'hA5);
        tbl[3]  = mk(1, 1, 9'h004, 'h11, 1, 9'h008, 0, 0, 'hA5);
        tbl[4]  = mk(1, 0, 9'h000, 'h0,  1, 9'h008, 1, 1, 'h0);
        tbl[5]  = mk(1, 1, 9'h004, 'h22, 1, 9'h009, 1, 1, 'h0);
        tbl[6]  = mk(1, 0, 9'h000, 'h0,  1, 9'h004, 1, 1, 'h22);
        tbl[7]  = mk(1, 1, 9'h009, 'h33, 1, 9'h004, 1, 1, 'h22);
        tbl[8]  = mk(1, 0, 9'h000, 'h0,  1, 9'h009, 1, 1, 'h33);
        tbl[9]  = mk(0, 1, 9'h009, 'h44, 1, 9'h00D, 1, 0, 'h33);
        tbl[10] = mk(1, 0, 9'h000, 'h0,  1, 9'h009, 1, 1, 'h33);
        for (int i = 0; i < 11; i++) begin
            ce = tbl[i].ce; we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; re = tbl[i].re; ra = tbl[i].ra;
            #1 chkb($sformatf("tbl%0d_rd_ready", i), rd_rdy, tbl[i].rdy);
            cyc();
            chkb($sformatf("tbl%0d_rd_valid", i), rd_val, tbl[i].val);
            chkw($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].data);
        end
        idle();
        cyc();

        s_ce = 1'b1; s_we = 1'b1; s_wa = 4'd3; s_wd = 8'h5A; s_re = 1'b1; s_ra = 4'd7;
        #1 chkb("small_conflict_rdy", s_rd_rdy, 1'b0);
        cyc();
        chkb("small_conflict_valid", s_rd_val, 1'b0);
        s_we = 1'b0; s_ra = 4'd3;
        #1 chkb("small_read_rdy", s_rd_rdy, 1'b1);
        cyc();
        chkb("small_read_valid", s_rd_val, 1'b1);
        chki("small_read_data", int'(s_rd_data), 'h5A);
        for (int i = 0; i < 6; i++) begin
            s_we = 1'b1; s_wa = 4'($urandom()); s_ra = 4'($urandom()); s_wd = 8'($urandom());
            #1 chkb("small_refuse_rdy", s_rd_rdy, 1'b0);
            cyc();
            chkb("small_refuse_valid", s_rd_val, 1'b0);
        end
        s_ce = 1'b0; s_we = 1'b0; s_re = 1'b0;

        for (int a = 0; a < 512; a++) begin
            ce = 1'b1; we = 1'b1; wa = A'(a); wd = rnd();
            cyc();
        end
        idle();
        for (int i = 0; i < 20; i++) begin
            ce = 1'b1; re = 1'b1; ra = A'($urandom());
            cyc();
        end
        idle();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cnt = 1; n = 0;
        for (int i = 0; i < 400; i++) begin
            clr = (cnt == 50);
            ce = busy & 1'($urandom()); we = 1'($urandom()); re = 1'($urandom());
            wa = A'($urandom()); ra = A'($urandom()); wd = rnd();
            cyc();
            if (!last_busy) break;
            n++;
            cnt++;
        end
        idle();
        chki("clear_busy_cycles", n, 178);
        nz = 0;
        for (int a = 0; a < 512; a++) begin
            ce = 1'b1; re = 1'b1; ra = A'(a);
            cyc();
            if (rd_val !== 1'b1 || rd_data !== '0) nz++;
        end
        idle();
        cyc();
        chki("cleared_reads_nonzero", nz, 0);

        for (int i = 0; i < 2000; i++) begin
            ce = ($urandom_range(3, 0) != 0);
            we = 1'($urandom()); re = 1'($urandom());
            wa = ($urandom_range(7, 0) == 0) ? A'($urandom()) : A'($urandom_range(31, 0));
            ra = ($urandom_range(7, 0) == 0) ? A'($urandom()) : A'($urandom_range(31, 0));
            wd = rnd();
            clr = ($urandom_range(299, 0) == 0);
            cyc();
        end
        idle();
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (!last_busy) break;
        end
        chkb("idle_before_reset", busy, 1'b0);

        ce = 1'b1; we = 1'b1; wa = 9'h012; wd = 'hA5;
        cyc();
        idle();
        ce = 1'b1; re = 1'b1; ra = 9'h012;
        cyc();
        idle();
        chkb("pre_reset_valid", rd_val, 1'b1);
        chkw("pre_reset_data", rd_data, 'hA5);
        #2 rst_n = 1'b0;
        #1;
        chkb("abort_valid", rd_val, 1'b0);
        chkw("abort_data", rd_data, '0);
        chkb("abort_busy", busy, 1'b1);
        chkb("abort_wr_ready", wr_rdy, 1'b0);
        chkb("abort_rd_ready", rd_rdy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 130; i++) cyc();
        ce = 1'b1; re = 1'b1; ra = 9'h012;
        cyc();
        idle();
        chkb("post_reset_valid", rd_val, 1'b1);
        chkw("post_reset_data", rd_data, '0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/banked_neuron_ram.md
BANKED_NEURON_RAM -- requirements
Module: banked_neuron_ram

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 309, neuron state word width (NID|Valid|Ntype|Vmem|Gex|Gin|RefVal|ExWeight|InWeight|Vth).
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, giving total depth 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter BANK_BITS, default 2, giving NUM_BANKS = 2**BANK_BITS single-port banks; legal range 0 to ADDR_WIDTH-1.
REQ-004 SHALL have Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have ResetN, input, 1; reset is asynchronous and active-low.
REQ-006 SHALL have ChipEnable, input, 1, which gates acceptance of reads and writes.
REQ-007 SHALL have Clear, input, 1, a one-cycle request to zero the whole array.
REQ-008 SHALL have Busy, output, 1, high while a clear sweep runs.
REQ-009 SHALL have WrEnable input 1, WrAddress input ADDR_WIDTH, WrData input WORD_WIDTH, WrReady output 1.
REQ-010 SHALL have RdEnable input 1, RdAddress input ADDR_WIDTH, RdReady output 1, RdData output WORD_WIDTH, RdValid output 1.

Function
REQ-011 SHALL interleave banks: bank = address[BANK_BITS-1:0], row = address[ADDR_WIDTH-1:BANK_BITS].
REQ-012 SHALL implement FSM states CLEAR and IDLE only.
REQ-013 SHALL in CLEAR write all-zero to row ClearRow of every bank per cycle, ClearRow counting 0 to 2**(ADDR_WIDTH-BANK_BITS)-1, then enter IDLE next cycle.
REQ-014 SHALL hold Busy=1 exactly while in CLEAR; the sweep takes 2**(ADDR_WIDTH-BANK_BITS) cycles and is independent of ChipEnable.
REQ-015 SHALL on Clear=1 in IDLE enter CLEAR with ClearRow=0 at the next edge; Clear=1 during CLEAR restarts ClearRow at 0.
REQ-016 SHALL drive WrReady = RdReady = 0 while in CLEAR; write and read requests there are dropped, not queued.
REQ-017 SHALL in IDLE drive WrReady = 1; a write is accepted when ChipEnable & WrEnable & WrReady and commits WrData at that edge.
REQ-018 SHALL in IDLE drive RdReady = 0 when ChipEnable & WrEnable and WrAddress bank equals RdAddress bank (write priority on bank conflict); otherwise RdReady = 1.
REQ-019 SHALL accept a read when ChipEnable & RdEnable & RdReady, presenting the stored word on RdData with RdValid=1 exactly one cycle later.
REQ-020 SHALL pulse RdValid for one cycle per accepted read and hold RdData unchanged until the next accepted read.
REQ-021 SHALL allow one write and one read in the same cycle when they target different banks, with no mutual effect.
REQ-022 SHALL return the new word for a read accepted in any cycle after a write to the same address commits.
REQ-023 SHALL leave array contents, RdData and ClearRow unchanged when ChipEnable=0 in IDLE.
REQ-024 SHALL generate readiness combinationally from state and request inputs only; no combinational path from WrData to any output.

Reset
REQ-025 SHALL on ResetN=0 asynchronously force state CLEAR, ClearRow=0, RdData=0, RdValid=0; hence Busy=1, WrReady=0, RdReady=0.
REQ-026 SHALL on ResetN release begin the clear sweep at the first rising edge, so the array reads all-zero once Busy falls.
REQ-027 SHALL on ResetN assertion mid-sweep or mid-read abort the operation and discard any pending RdValid.

Verification
REQ-028 SHALL verify reset: defaults, release ResetN -> Busy=1 for 128 cycles, then Busy=0; a read of address 0x1FF returns 0 with RdValid one cycle later.
REQ-029 SHALL verify write/read: write 0x...A5 to 0x012, then read 0x012 -> RdData=0x...A5, RdValid high for exactly one cycle, RdData held afterwards.
REQ-030 SHALL verify bank conflict: write to 0x004 and read 0x008 in the same cycle -> RdReady=0 and the read is dropped; write to 0x004 and read 0x009 together -> both accepted.
REQ-031 SHALL verify Clear: fill addresses 0..511, pulse Clear, pulse Clear again at sweep cycle 50 -> Busy stays high 178 cycles total; every address then reads 0; requests during Busy are dropped.
REQ-032 SHALL verify ChipEnable=0 with WrEnable=1 and RdEnable=1 -> no array change and no RdValid.
REQ-033 SHALL verify parameterisation: BANK_BITS=0 with ADDR_WIDTH=4 -> 16-cycle sweep, and every simultaneous read with an accepted write is refused.
